// File: rtl/hash_pkg.sv
// Shared digest types, constants and helpers for the weights digest path.
package hash_pkg;

  localparam int unsigned DIGEST_BITS   = 32;
  localparam int unsigned ROT           = 5;
  localparam int unsigned MAX_AXI_WIDTH = 1024;

  typedef logic [DIGEST_BITS-1:0] digest_t;

  localparam digest_t DIGEST_SEED = 32'h811C9DC5;

  typedef enum logic {IDLE, RUN} wda_state_e;

  // XOR of all 32-bit lanes; callers zero-extend narrower buses, which leaves the result unchanged.
  function automatic digest_t fold32(input logic [MAX_AXI_WIDTH-1:0] data);
    digest_t acc;
    acc = '0;
    for (int unsigned i = 0; i < MAX_AXI_WIDTH / 32; i++) begin
      acc = acc ^ data[i*32 +: 32];
    end
    return acc;
  endfunction

  function automatic digest_t rotl(input digest_t h);
    return {h[DIGEST_BITS-1-ROT:0], h[DIGEST_BITS-1:DIGEST_BITS-ROT]};
  endfunction

endpackage

// File: rtl/digest_fifo.sv
// Synchronous FIFO for finished digests; a push into a full queue succeeds only alongside a pop.
module digest_fifo #(
  parameter int unsigned WIDTH = 56,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/weights_digest_accum.sv
// Passive R-channel snooper folding accepted beats into per-segment digests.
// Optional WDA_ID_FILTER_EN: only beats whose s_rid matches cfg_id are counted.
module weights_digest_accum
  import hash_pkg::*;
#(
  parameter int unsigned AXI_WIDTH    = 128,
  parameter int unsigned AXI_ID_WIDTH = 6,
  parameter int unsigned DIGEST_BITS  = hash_pkg::DIGEST_BITS,
  parameter int unsigned CNT_BITS     = 24,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_rvalid,
  input  logic                    s_rready,
  input  logic [AXI_WIDTH-1:0]    s_rdata,
  input  logic [AXI_ID_WIDTH-1:0] s_rid,
  input  logic                    cfg_start,
  input  logic [CNT_BITS-1:0]     cfg_beats,
  input  logic [CNT_BITS-1:0]     cfg_segs,
  input  logic [AXI_ID_WIDTH-1:0] cfg_id,
  output logic                    m_digest_valid,
  input  logic                    m_digest_ready,
  output logic [DIGEST_BITS-1:0]  m_digest_data,
  output logic [CNT_BITS-1:0]     m_digest_idx,
  output logic                    busy,
  output logic                    run_done,
  output logic                    overflow
);

  localparam int unsigned ENTRY_W = DIGEST_BITS + CNT_BITS;

  wda_state_e          state, state_n;
  digest_t             h, h_n, h_next_c;
  logic [CNT_BITS-1:0] beat_cnt, beat_cnt_n;
  logic [CNT_BITS-1:0] seg_cnt, seg_cnt_n;
  logic [CNT_BITS-1:0] beats_q, beats_n;
  logic [CNT_BITS-1:0] segs_q, segs_n;
  logic                run_done_n, overflow_n;
  logic                id_ok_c, beat_c, push_c, pop_c;
  logic                fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]  rd_entry;

`ifdef WDA_ID_FILTER_EN
  assign id_ok_c = (s_rid == cfg_id);
`else
  logic unused_id;
  assign unused_id = ^{s_rid, cfg_id};
  assign id_ok_c   = 1'b1;
`endif

  assign beat_c   = s_rvalid & s_rready & id_ok_c;
  assign pop_c    = m_digest_valid & m_digest_ready;
  assign h_next_c = rotl(h) ^ fold32(MAX_AXI_WIDTH'(s_rdata));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      h        <= DIGEST_SEED;
      beat_cnt <= '0;
      seg_cnt  <= '0;
      beats_q  <= '0;
      segs_q   <= '0;
      run_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      h        <= h_n;
      beat_cnt <= beat_cnt_n;
      seg_cnt  <= seg_cnt_n;
      beats_q  <= beats_n;
      segs_q   <= segs_n;
      run_done <= run_done_n;
      overflow <= overflow_n;
    end
  end

  // Next-state and per-beat accumulation; a dropped digest still advances the segment.
  always_comb begin
    state_n    = state;
    h_n        = h;
    beat_cnt_n = beat_cnt;
    seg_cnt_n  = seg_cnt;
    beats_n    = beats_q;
    segs_n     = segs_q;
    run_done_n = 1'b0;
    overflow_n = overflow;
    push_c     = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_n    = RUN;
          beats_n    = (cfg_beats == '0) ? CNT_BITS'(1) : cfg_beats;
          segs_n     = (cfg_segs == '0) ? CNT_BITS'(1) : cfg_segs;
          h_n        = DIGEST_SEED;
          beat_cnt_n = '0;
          seg_cnt_n  = '0;
          overflow_n = 1'b0;
        end
      end
      RUN: begin
        if (beat_c) begin
          h_n        = h_next_c;
          beat_cnt_n = beat_cnt + CNT_BITS'(1);
          if (beat_cnt == beats_q - CNT_BITS'(1)) begin
            push_c     = 1'b1;
            h_n        = DIGEST_SEED;
            beat_cnt_n = '0;
            seg_cnt_n  = seg_cnt + CNT_BITS'(1);
            if (fifo_full && !pop_c) overflow_n = 1'b1;
            if (seg_cnt == segs_q - CNT_BITS'(1)) begin
              state_n    = IDLE;
              run_done_n = 1'b1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  digest_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .pop     (pop_c),
    .wr_data ({h_next_c, seg_cnt}),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_digest_valid = ~fifo_empty;
  assign m_digest_data  = rd_entry[ENTRY_W-1 -: DIGEST_BITS];
  assign m_digest_idx   = rd_entry[CNT_BITS-1:0];
  assign busy           = (state == RUN);

endmodule

// File: tb/tb_weights_digest_accum.sv
// Directed self-checking bench for weights_digest_accum.
module tb_weights_digest_accum;

  localparam logic [31:0] SEED = 32'h811C9DC5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_rvalid = 1'b0;
  logic         s_rready = 1'b0;
  logic [127:0] s_rdata = '0;
  logic [5:0]   s_rid = '0;
  logic         cfg_start = 1'b0;
  logic [23:0]  cfg_beats = '0;
  logic [23:0]  cfg_segs = '0;
  logic [5:0]   cfg_id = '0;
  logic         m_digest_valid;
  logic         m_digest_ready = 1'b0;
  logic [31:0]  m_digest_data;
  logic [23:0]  m_digest_idx;
  logic         busy;
  logic         run_done;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  weights_digest_accum dut (
    .clk            (clk),
    .rst            (rst),
    .s_rvalid       (s_rvalid),
    .s_rready       (s_rready),
    .s_rdata        (s_rdata),
    .s_rid          (s_rid),
    .cfg_start      (cfg_start),
    .cfg_beats      (cfg_beats),
    .cfg_segs       (cfg_segs),
    .cfg_id         (cfg_id),
    .m_digest_valid (m_digest_valid),
    .m_digest_ready (m_digest_ready),
    .m_digest_data  (m_digest_data),
    .m_digest_idx   (m_digest_idx),
    .busy           (busy),
    .run_done       (run_done),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] step(input logic [31:0] h, input logic [127:0] d);
    return {h[26:0], h[31:27]} ^ d[31:0] ^ d[63:32] ^ d[95:64] ^ d[127:96];
  endfunction

  function automatic logic [127:0] dat(input int i);
    return {32'(i * 3 + 1), 32'hA5A5_0000 ^ 32'(i), 32'(i << 8), 32'hDEAD_BEEF};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [23:0] beats, input logic [23:0] segs);
    cfg_beats = beats;
    cfg_segs  = segs;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic beat(input logic [127:0] d, input logic [5:0] rid);
    s_rvalid = 1'b1;
    s_rready = 1'b1;
    s_rdata  = d;
    s_rid    = rid;
    tick();
    s_rvalid = 1'b0;
    s_rready = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] d, input logic [23:0] idx);
    check({tag, "_valid"}, 32'(m_digest_valid), 32'd1);
    check({tag, "_data"}, m_digest_data, d);
    check({tag, "_idx"}, 32'(m_digest_idx), 32'(idx));
    m_digest_ready = 1'b1;
    tick();
    m_digest_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] h;
    logic [31:0] exp_d [6];

    // Reset state
    tick();
    check("rst_valid", 32'(m_digest_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(run_done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick();

    // 1: single zero beat
    start(24'd1, 24'd1);
    check("t1_busy", 32'(busy), 32'd1);
    beat('0, 6'd0);
    check("t1_done", 32'(run_done), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_data", m_digest_data, 32'h2393B8B0);
    tick();
    check("t1_done_pulse", 32'(run_done), 32'd0);
    pop_check("t1", 32'h2393B8B0, 24'd0);
    check("t1_empty", 32'(m_digest_valid), 32'd0);

    // 2: rvalid without rready never counts
    start(24'd4, 24'd1);
    s_rvalid = 1'b1;
    s_rdata  = {4{32'hFFFF_0000}};
    for (int i = 0; i < 10; i++) tick();
    s_rvalid = 1'b0;
    check("t2_nopush", 32'(m_digest_valid), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    h = SEED;
    for (int i = 0; i < 4; i++) begin
      h = step(h, '0);
      beat('0, 6'd0);
    end
    check("t2_done", 32'(run_done), 32'd1);
    pop_check("t2", h, 24'd0);

    // 3: six segments into a four-deep queue
    start(24'd2, 24'd6);
    h = SEED;
    for (int i = 0; i < 12; i++) begin
      h = step(h, dat(i));
      if (i % 2 == 1) begin
        exp_d[i/2] = h;
        h = SEED;
      end
      beat(dat(i), 6'd0);
    end
    check("t3_done", 32'(run_done), 32'd1);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_idle", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) pop_check("t3", exp_d[k], 24'(k));
    check("t3_empty", 32'(m_digest_valid), 32'd0);

    // 4: push into full queue with a simultaneous pop
    start(24'd1, 24'd5);
    check("t4_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      exp_d[i] = step(SEED, dat(20 + i));
      beat(dat(20 + i), 6'd0);
    end
    exp_d[4] = step(SEED, dat(24));
    m_digest_ready = 1'b1;
    beat(dat(24), 6'd0);
    m_digest_ready = 1'b0;
    check("t4_ovf", 32'(overflow), 32'd0);
    check("t4_done", 32'(run_done), 32'd1);
    for (int k = 1; k < 5; k++) pop_check("t4", exp_d[k], 24'(k));
    check("t4_empty", 32'(m_digest_valid), 32'd0);

    // 5: reset mid-segment, then rerun
    start(24'd8, 24'd2);
    h = SEED;
    for (int i = 0; i < 8; i++) begin
      h = step(h, dat(40 + i));
      beat(dat(40 + i), 6'd0);
    end
    for (int i = 0; i < 3; i++) beat(dat(60 + i), 6'd0);
    check("t5_queued", 32'(m_digest_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_flush", 32'(m_digest_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("t5_nodone", 32'(run_done), 32'd0);
    start(24'd8, 24'd1);
    for (int i = 0; i < 8; i++) beat(dat(40 + i), 6'd0);
    check("t5_done", 32'(run_done), 32'd1);
    pop_check("t5", h, 24'd0);

`ifdef WDA_ID_FILTER_EN
    // 6: only rid 2 beats count
    cfg_id = 6'd2;
    start(24'd2, 24'd1);
    h = step(step(SEED, dat(70)), dat(72));
    beat(dat(70), 6'd2);
    beat(dat(71), 6'd5);
    check("t6_busy", 32'(busy), 32'd1);
    beat(dat(72), 6'd2);
    beat(dat(73), 6'd5);
    pop_check("t6", h, 24'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
